// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned FETCH_DEPTH   = 4;
  localparam int unsigned FETCH_AW      = 16;
  localparam int unsigned FETCH_DW      = 16;
  localparam int unsigned FETCH_ENTRY_W = FETCH_AW + FETCH_DW;
  localparam int unsigned FETCH_CNT_W   = cnt_width(FETCH_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push and a pop in the same
// cycle are both honoured, even when full.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_ENTRY_W,
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned CW   = cnt_width(DEPTH),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // NOTE: non-blocking assignments for all flop state so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides validity,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order memory requests,
// buffered {pc, instr} delivery to decode, redirect flush with drop counting.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  parameter int unsigned AW    = FETCH_AW,
  parameter int unsigned DW    = FETCH_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_cur,
  output logic          pc_en,
  output logic [AW-1:0] next_pc,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  input  logic          id_ready
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  fetch_state_e  state_q;
  logic [CW-1:0] drop_cnt_q;
  logic          active_q;

  logic [AW-1:0] pend_addr;
  logic          pend_full, pend_empty;
  logic [CW-1:0] outstanding;

  logic [AW-1:0] head_pc;
  logic [DW-1:0] head_instr;
  logic          ibuf_full, ibuf_empty, ibuf_push;
  logic [CW-1:0] occupancy;

  logic          redir, can_issue, accept, rsp_ok, id_pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] outst_after, drop_left;

  assign redir       = active_q && redirect_valid;
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign can_issue   = active_q && (state_q == RUN) && !redirect_valid
                       && (credit_used < CREDIT_MAX);
  assign accept      = can_issue && imem_req_ready;
  // A response with nothing pending is a protocol error and is ignored.
  assign rsp_ok      = imem_rsp_valid && !pend_empty;
  assign ibuf_push   = rsp_ok && (state_q == RUN) && !redirect_valid;

  assign id_valid    = !ibuf_empty && !redirect_valid;
  assign id_pop      = id_valid && id_ready;
  assign id_pc       = id_valid ? head_pc : '0;
  assign id_instr    = id_valid ? head_instr : '0;

  assign imem_req_valid = can_issue;
  assign imem_req_addr  = active_q ? pc_cur : '0;

  always_comb begin
    pc_en   = accept || redir;
    next_pc = active_q ? pc_cur : '0;
    if (redir)       next_pc = redirect_pc;
    else if (accept) next_pc = pc_cur + AW'(1);
  end

  always_comb begin
    outst_after = outstanding - CW'(rsp_ok);
    drop_left   = drop_cnt_q - CW'(rsp_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      drop_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      active_q <= 1'b1;
      unique case (state_q)
        RUN: begin
          if (redir && (outst_after != '0)) begin
            state_q    <= FLUSH;
            drop_cnt_q <= outst_after;
          end
        end
        FLUSH: begin
          drop_cnt_q <= drop_left;
          if (drop_left == '0) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (rsp_ok),
    .flush_i (1'b0),
    .wdata_i (pc_cur),
    .rdata_o (pend_addr),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (outstanding)
  );

  sync_fifo #(.WIDTH(AW + DW), .DEPTH(DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ibuf_push),
    .pop_i   (id_pop),
    .flush_i (redir),
    .wdata_i ({pend_addr, imem_rsp_data}),
    .rdata_o ({head_pc, head_instr}),
    .full_o  (ibuf_full),
    .empty_o (ibuf_empty),
    .count_o (occupancy)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !pend_empty);
  a_no_req_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> !pend_full || rsp_ok);
  a_no_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ibuf_push |-> !ibuf_full || id_pop);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and latency-programmable memory
// models, with a scoreboard of accepted fetches checked at decode handshakes.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc_cur;
  logic          pc_en;
  logic [AW-1:0] next_pc;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_en          (pc_en),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // PC register fed by the DUT
  logic [AW-1:0] pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_q <= '0;
    else if (pc_en) pc_q <= next_pc;
  end
  assign pc_cur = pc_q;

  // In-order memory with fixed latency 'lat' (>= 1 cycle after acceptance)
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } mrsp_t;
  mrsp_t mq[$];
  int    lat = 1;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{instr_of(imem_req_addr), cyc + lat - 1});
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mq[0].data;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int acc_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes at the falling edge, then advance to just past the next rising edge.
  task automatic tick();
    logic          acc, cons, redir;
    logic [AW-1:0] inc_pc;
    exp_t          e;
    @(negedge clk);
    acc   = imem_req_valid && imem_req_ready;
    cons  = id_valid && id_ready;
    redir = redirect_valid && rst_n;
    if (cons) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("id_pc", 32'(id_pc), 32'(e.pc));
        check("id_instr", 32'(id_instr), 32'(e.instr));
      end
    end
    if (acc) begin
      inc_pc = pc_cur + 16'd1;
      check("acc_pc_en", 32'(pc_en), 32'd1);
      check("acc_next_pc", 32'(next_pc), 32'(inc_pc));
      sb.push_back('{pc_cur, instr_of(pc_cur)});
      acc_count++;
    end
    if (redir) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_req();
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
  endtask

  task automatic wait_for_id();
    for (int i = 0; i < 20 && !id_valid; i++) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"},  32'(imem_req_addr),  32'd0);
    check({tag, "_id_valid"},  32'(id_valid),       32'd0);
    check({tag, "_id_pc"},     32'(id_pc),          32'd0);
    check({tag, "_id_instr"},  32'(id_instr),       32'd0);
    check({tag, "_pc_en"},     32'(pc_en),          32'd0);
    check({tag, "_next_pc"},   32'(next_pc),        32'd0);
  endtask

  // Leaves the bench just after reset release (cycle 0).
  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    acc_count = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic measure_first_id(input string tag);
    int first;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      if (id_valid && first < 0) begin
        first = k;
        check({tag, "_first_pc"}, 32'(id_pc), 32'd0);
      end
      tick();
    end
    check({tag, "_first_idv_cycle"}, 32'(first), 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    lat            = 1;

    // 1: streaming fetch from 0 with single-cycle memory
    apply_reset();
    measure_first_id("t1");
    repeat (10) tick();
    check("t1_stream_acc", 32'(acc_count > 8), 32'd1);

    // 2: decode stalled -> credit limit of DEPTH requests
    id_ready = 1'b0;
    apply_reset();
    repeat (12) tick();
    check("t2_acc_count", 32'(acc_count), 32'd4);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_pc_en", 32'(pc_en), 32'd0);
    check("t2_pc_hold", 32'(pc_cur), 32'h4);
    check("t2_next_pc", 32'(next_pc), 32'h4);
    check("t2_head_pc", 32'(id_pc), 32'h0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("t2_reissue_valid", 32'(imem_req_valid), 32'd1);
    check("t2_reissue_addr", 32'(imem_req_addr), 32'h4);
    tick();
    check("t2_full_again", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    imem_req_ready = 1'b0;
    repeat (8) tick();
    check("t2_drained", 32'(id_valid), 32'd0);

    // 3: redirect with two requests in flight
    lat = 4;
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    #1;
    check("t3_redir_pc_en", 32'(pc_en), 32'd1);
    check("t3_redir_next_pc", 32'(next_pc), 32'h0100);
    check("t3_redir_id_valid", 32'(id_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("t3_flush_no_req", 32'(imem_req_valid), 32'd0);
    check("t3_flush_buf_empty", 32'(id_valid), 32'd0);
    wait_for_req();
    check("t3_resume_valid", 32'(imem_req_valid), 32'd1);
    check("t3_resume_addr", 32'(imem_req_addr), 32'h0100);

    // 4: second redirect while still flushing
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0150;
    tick();
    redirect_pc = 16'h0200;
    #1;
    check("t4_flush_redir_next_pc", 32'(next_pc), 32'h0200);
    check("t4_flush_redir_pc_en", 32'(pc_en), 32'd1);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("t4_still_flush", 32'(imem_req_valid), 32'd0);
    wait_for_req();
    check("t4_resume_addr", 32'(imem_req_addr), 32'h0200);
    wait_for_id();
    check("t4_first_id_valid", 32'(id_valid), 32'd1);
    check("t4_first_id_pc", 32'(id_pc), 32'h0200);
    repeat (4) tick();

    // 5: PC wrap at the top of the address space
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    wait_for_req();
    check("t5_req_addr", 32'(imem_req_addr), 32'hFFFF);
    check("t5_wrap_next_pc", 32'(next_pc), 32'h0000);
    check("t5_wrap_pc_en", 32'(pc_en), 32'd1);
    wait_for_id();
    check("t5_id_pc_ffff", 32'(id_pc), 32'hFFFF);
    tick();
    wait_for_id();
    check("t5_id_pc_0000", 32'(id_pc), 32'h0000);
    tick();

    // 6: asynchronous reset with traffic pending
    id_ready = 1'b0;
    lat = 3;
    repeat (6) tick();
    check("t6_pending_id", 32'(id_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    sb.delete();
    @(posedge clk);
    #1;
    lat = 1;
    id_ready = 1'b1;
    rst_n = 1'b1;
    measure_first_id("t6");
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
